// File: rtl/drug_counter_pkg.sv
// Shared keypad definitions: matrix geometry, key-code map and scanner states.
package drug_counter_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } scan_state_t;

  // Phone-style layout: rows 1-2-3 / 4-5-6 / 7-8-9 / CLR-0-ENTER, code = row*4 + col
  localparam logic [KEY_W-1:0] KEY_1     = 4'd0;
  localparam logic [KEY_W-1:0] KEY_2     = 4'd1;
  localparam logic [KEY_W-1:0] KEY_3     = 4'd2;
  localparam logic [KEY_W-1:0] KEY_4     = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5     = 4'd5;
  localparam logic [KEY_W-1:0] KEY_6     = 4'd6;
  localparam logic [KEY_W-1:0] KEY_7     = 4'd8;
  localparam logic [KEY_W-1:0] KEY_8     = 4'd9;
  localparam logic [KEY_W-1:0] KEY_9     = 4'd10;
  localparam logic [KEY_W-1:0] KEY_CLR   = 4'd12;
  localparam logic [KEY_W-1:0] KEY_0     = 4'd13;
  localparam logic [KEY_W-1:0] KEY_ENTER = 4'd14;

  function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchroniser for the active-low keypad row returns; idles at "no key".
module kp_sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: rotating active-low column strobe, debounced press/release,
// one key_valid pulse per physical press.
//
// state    | meaning
// SCAN     | rotate columns, sample rows at the end of each slot
// DEBOUNCE | column held, waiting for the latched row pattern to stay stable
// RELEASE  | key reported, column held, waiting for all rows to stay released
module keypad_matrix_scanner
  import drug_counter_pkg::*;
#(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  scan_in,
  output logic [COLS-1:0]  scan_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  scan_state_t      state_q, state_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [DEB_W-1:0] deb_q, deb_nxt;
  logic [1:0]       col_q, col_nxt;
  logic [1:0]       row_q, row_nxt;
  logic [KEY_W-1:0] key_code_nxt;
  logic             key_valid_nxt;
  logic             key_held_nxt;
  logic [ROWS-1:0]  rs;
  logic [ROWS-1:0]  row_pat;
  logic [1:0]       low_row;
  logic [2:0]       low_cnt;
  logic             one_low;

  kp_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (scan_in),
    .q   (rs)
  );

  // Count low rows; anything other than exactly one is ghosting or multi-press.
  always_comb begin
    low_row = 2'd0;
    low_cnt = 3'd0;
    for (int i = 0; i < ROWS; i++) begin
      if (!rs[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_row = 2'(i);
      end
    end
  end

  assign one_low = (low_cnt == 3'd1);
  assign row_pat = ~(4'b0001 << row_q);

  always_comb begin
    state_nxt     = state_q;
    div_nxt       = div_q;
    deb_nxt       = deb_q;
    col_nxt       = col_q;
    row_nxt       = row_q;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    key_held_nxt  = key_held;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_nxt = '0;
          if (one_low) begin
            row_nxt   = low_row;
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col_q + 2'd1;
          end
        end else begin
          div_nxt = div_q + DIV_ONE;
        end
      end
      DEBOUNCE: begin
        if (rs == row_pat) begin
          if (deb_q == DEB_LAST) begin
            key_code_nxt  = key_code_of(row_q, col_q);
            key_valid_nxt = 1'b1;
            key_held_nxt  = 1'b1;
            deb_nxt       = '0;
            state_nxt     = RELEASE;
          end else begin
            deb_nxt = deb_q + DEB_ONE;
          end
        end else begin
          deb_nxt   = '0;
          div_nxt   = '0;
          col_nxt   = col_q + 2'd1;
          state_nxt = SCAN;
        end
      end
      RELEASE: begin
        if (rs == 4'b1111) begin
          if (deb_q == DEB_LAST) begin
            key_held_nxt = 1'b0;
            deb_nxt      = '0;
            div_nxt      = '0;
            col_nxt      = col_q + 2'd1;
            state_nxt    = SCAN;
          end else begin
            deb_nxt = deb_q + DEB_ONE;
          end
        end else begin
          deb_nxt = '0;
        end
      end
      default: begin
        state_nxt = SCAN;
        div_nxt   = '0;
        deb_nxt   = '0;
      end
    endcase
  end

  // Strobe is registered so the pins never see decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      div_q     <= '0;
      deb_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      scan_out  <= 4'b1110;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      div_q     <= div_nxt;
      deb_q     <= deb_nxt;
      col_q     <= col_nxt;
      row_q     <= row_nxt;
      scan_out  <= ~(4'b0001 << col_nxt);
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a keypad model answers the column strobes and
// presses are checked as events (count, code, latency window, held/release behaviour).
module tb_keypad_matrix_scanner;

  localparam int SD      = 4;
  localparam int DC      = 8;
  localparam int LAT_MAX = 2 + 4 * SD + DC + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] scan_in;
  logic [3:0] scan_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       kp_press = 1'b0;
  logic [1:0] kp_row = 2'd0;
  logic [1:0] kp_col = 2'd0;
  logic       ov_en = 1'b0;
  logic [3:0] ov_val = 4'hF;

  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int onehot_msgs = 0;
  logic [3:0] last_code = 4'd0;
  logic prev_valid = 1'b0;

  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: the pressed key pulls its row low only while its column is strobed.
  assign scan_in = ov_en ? ov_val :
                   (kp_press && !scan_out[kp_col]) ? ~(4'b0001 << kp_row) : 4'hF;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    total++;
    if ($countones(~scan_out) != 1) begin
      bad++;
      if (onehot_msgs < 10) $display("FAIL scan_onehot: scan_out=%b required exactly one low bit", scan_out);
      onehot_msgs++;
    end
    if (key_valid) begin
      total++;
      if (prev_valid) begin
        bad++;
        $display("FAIL valid_pulse: key_valid high 2+ cycles at cyc=%0d, required 1-cycle pulse", cyc);
      end
      nvalid++;
      last_code = key_code;
      last_valid_cyc = cyc;
    end
    prev_valid = key_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int v0, input int budget);
    for (int i = 0; i < budget && nvalid == v0; i++) tick(1);
    tick(1);
  endtask

  task automatic wait_release(input int t1, input string name);
    int lat;
    for (int i = 0; i < DC + 12 && key_held; i++) tick(1);
    lat = cyc - t1;
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL %s_release: key_held=%b after %0d cycles, required 0", name, key_held, lat);
    end else if (lat < DC || lat > DC + 4) begin
      bad++;
      $display("FAIL %s_release_lat: release took %0d cycles, required %0d..%0d", name, lat, DC, DC + 4);
    end
  endtask

  task automatic press_and_check(input logic [1:0] r, input logic [1:0] c, input int hold, input string name);
    int v0, t0, lat;
    logic [3:0] exp_code, exp_col, s0;
    v0 = nvalid;
    exp_code = 4'(r * 4 + c);
    exp_col = ~(4'b0001 << c);
    kp_row = r;
    kp_col = c;
    kp_press = 1'b1;
    t0 = cyc;
    wait_valid(v0, LAT_MAX);
    total++;
    if (nvalid != v0 + 1) begin
      bad++;
      $display("FAIL %s_valid: got %0d pulses, required 1", name, nvalid - v0);
    end else begin
      lat = last_valid_cyc - t0;
      total++;
      if (last_code !== exp_code) begin
        bad++;
        $display("FAIL %s_code: key_code=%0d, required %0d", name, last_code, exp_code);
      end
      total++;
      if (lat < DC || lat > LAT_MAX) begin
        bad++;
        $display("FAIL %s_latency: %0d cycles, required %0d..%0d", name, lat, DC, LAT_MAX);
      end
    end
    tick(hold);
    total++;
    if (key_held !== 1'b1 || scan_out !== exp_col || nvalid != v0 + 1) begin
      bad++;
      $display("FAIL %s_hold: held=%b scan_out=%b pulses=%0d, required held=1 scan_out=%b pulses=1",
               name, key_held, scan_out, nvalid - v0, exp_col);
    end
    kp_press = 1'b0;
    wait_release(cyc, name);
    tick(1);
    s0 = scan_out;
    tick(SD);
    total++;
    if (scan_out === s0 || nvalid != v0 + 1) begin
      bad++;
      $display("FAIL %s_resume: scan_out stuck at %b, pulses=%0d, required rotation and 1 pulse",
               name, scan_out, nvalid - v0);
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    rst = 1'b1;
    tick(3);
    total++;
    if (scan_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 || key_held !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: scan_out=%b valid=%b code=%0d held=%b, required 1110 0 0 0",
               scan_out, key_valid, key_code, key_held);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      exp = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (scan_out !== exp) begin
        bad++;
        $display("FAIL scan_rotate: edge %0d scan_out=%b, required %b", k, scan_out, exp);
      end
    end
  endtask

  task automatic test_single_key;
    press_and_check(2'd2, 2'd1, 10, "key9");
  endtask

  task automatic test_bounce;
    int v0, t_st;
    v0 = nvalid;
    kp_row = 2'd2;
    kp_col = 2'd1;
    for (int i = 0; i < 40; i++) begin
      kp_press = ((i / 3) % 2) == 0;
      tick(1);
    end
    kp_press = 1'b1;
    t_st = cyc;
    wait_valid(v0, LAT_MAX);
    tick(5);
    total++;
    if (nvalid != v0 + 1) begin
      bad++;
      $display("FAIL bounce_count: %0d pulses, required 1", nvalid - v0);
    end else begin
      total++;
      if (last_code !== 4'd9 || last_valid_cyc - t_st < DC) begin
        bad++;
        $display("FAIL bounce_code: code=%0d after %0d stable cycles, required code 9 after >=%0d",
                 last_code, last_valid_cyc - t_st, DC);
      end
    end
    kp_press = 1'b0;
    wait_release(cyc, "bounce");
    tick(2);
  endtask

  task automatic test_ghost;
    int v0, changes;
    logic [3:0] prev;
    v0 = nvalid;
    ov_en = 1'b1;
    ov_val = 4'b0011;
    prev = scan_out;
    changes = 0;
    for (int i = 0; i < 48; i++) begin
      tick(1);
      if (scan_out !== prev) begin
        total++;
        if (scan_out !== {prev[2:0], prev[3]}) begin
          bad++;
          $display("FAIL ghost_order: scan_out %b -> %b, required %b", prev, scan_out, {prev[2:0], prev[3]});
        end
        changes++;
        prev = scan_out;
      end
    end
    total++;
    if (changes < 11 || nvalid != v0) begin
      bad++;
      $display("FAIL ghost_scan: rotations=%0d pulses=%0d, required >=11 rotations and 0 pulses",
               changes, nvalid - v0);
    end
    ov_en = 1'b0;
    tick(3);
  endtask

  task automatic test_long_hold;
    int v0;
    v0 = nvalid;
    kp_row = 2'd3;
    kp_col = 2'd1;
    kp_press = 1'b1;
    wait_valid(v0, LAT_MAX);
    tick(100);
    total++;
    if (nvalid != v0 + 1 || last_code !== 4'd13 || key_held !== 1'b1) begin
      bad++;
      $display("FAIL long_hold: pulses=%0d code=%0d held=%b, required 1 13 1", nvalid - v0, last_code, key_held);
    end
    kp_press = 1'b0;
    tick(5);
    kp_press = 1'b1;
    tick(3);
    total++;
    if (key_held !== 1'b1) begin
      bad++;
      $display("FAIL release_bounce: key_held=%b, required 1", key_held);
    end
    kp_press = 1'b0;
    wait_release(cyc, "long_hold");
    total++;
    if (nvalid != v0 + 1) begin
      bad++;
      $display("FAIL long_hold_repeat: %0d pulses, required 1", nvalid - v0);
    end
    tick(2);
  endtask

  task automatic test_reset_mid_debounce;
    int v0;
    logic [3:0] prev;
    logic found;
    for (int i = 0; i < 20 && scan_out !== 4'b1110; i++) tick(1);
    kp_row = 2'd1;
    kp_col = 2'd2;
    kp_press = 1'b1;
    v0 = nvalid;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev = scan_out;
      tick(1);
      if (scan_out === 4'b1011 && prev !== 4'b1011) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rst_mid_find: column 2 strobe never seen, scan_out=%b required 1011", scan_out);
    end
    tick(8);
    rst = 1'b1;
    #1;
    total++;
    if (scan_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 || key_held !== 1'b0 || nvalid != v0) begin
      bad++;
      $display("FAIL rst_mid_values: scan_out=%b valid=%b code=%0d held=%b pulses=%0d, required 1110 0 0 0 0",
               scan_out, key_valid, key_code, key_held, nvalid - v0);
    end
    tick(2);
    rst = 1'b0;
    wait_valid(v0, LAT_MAX);
    tick(5);
    total++;
    if (nvalid != v0 + 1 || last_code !== 4'd6) begin
      bad++;
      $display("FAIL rst_mid_redetect: pulses=%0d code=%0d, required 1 and 6", nvalid - v0, last_code);
    end
    kp_press = 1'b0;
    wait_release(cyc, "rst_mid");
    tick(2);
  endtask

  task automatic test_random_keys;
    logic [1:0] r, c;
    for (int i = 0; i < 16; i++) begin
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 15));
      press_and_check(r, c, $urandom_range(0, 20), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_ghost();
    test_long_hold();
    test_reset_mid_debounce();
    test_random_keys();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
